// File: rtl/mem_bus_responder.sv
// rtl/mem_bus_responder.sv - memory-side responder for the cs/we/oe/addr/data bus
//
// Purpose: holds a 2^ADDR_WIDTH x DATA_WIDTH synchronous store and answers
// initiator accesses after WAIT_STATES wait cycles with a one-cycle ready
// pulse. Illegal control combinations (we == oe while cs) complete at once
// with err. Saturating read/write completion counters are kept for debug.
//
// Ports:
//   i_clk       clock, all state changes on the rising edge
//   i_rst       asynchronous active-high reset
//   i_addr      access address (full width indexes the store)
//   io_data     shared data bus, driven here only while cs & oe & !we
//   i_cs        chip select, request valid while high
//   i_we        write enable
//   i_oe        output enable (read)
//   o_ready     one-cycle completion pulse
//   o_err       one-cycle pulse with o_ready for an illegal access
//   o_rd_count  completed reads, saturating at 16'hFFFF
//   o_wr_count  completed writes, saturating at 16'hFFFF
module mem_bus_responder #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  inout  wire  [DATA_WIDTH-1:0] io_data,
  input  logic                  i_cs,
  input  logic                  i_we,
  input  logic                  i_oe,
  output logic                  o_ready,
  output logic                  o_err,
  output logic [15:0]           o_rd_count,
  output logic [15:0]           o_wr_count
);

  localparam int         DEPTH   = 1 << ADDR_WIDTH;
  localparam logic [3:0] LP_WAIT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [3:0]            r_wait_cnt;
  logic [3:0]            w_wait_cnt_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_is_write;
  logic                  r_illegal;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [15:0]           r_rd_count;
  logic [15:0]           r_wr_count;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  w_enter_ack;
  logic [ADDR_WIDTH-1:0] w_acc_addr;
  logic                  w_acc_write;
  logic                  w_acc_illegal;
  logic                  w_do_write;
  logic                  w_do_read;

  // With zero wait states the access completes on the same edge that samples
  // the request, so the live bus request (not the latched copy) selects the
  // memory operation while in IDLE.
  always_comb begin
    w_next_state    = r_state;
    w_wait_cnt_next = r_wait_cnt;
    w_enter_ack     = 1'b0;
    w_acc_addr      = r_addr;
    w_acc_write     = r_is_write;
    w_acc_illegal   = r_illegal;
    case (r_state)
      S_IDLE: begin
        w_acc_addr    = i_addr;
        w_acc_write   = i_we;
        w_acc_illegal = (i_we == i_oe);
        if (i_cs) begin
          if (w_acc_illegal || (WAIT_STATES == 0)) begin
            w_next_state = S_ACK;
            w_enter_ack  = 1'b1;
          end else begin
            w_next_state    = S_WAIT;
            w_wait_cnt_next = LP_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!i_cs) begin
          w_next_state = S_IDLE;
        end else begin
          w_wait_cnt_next = r_wait_cnt - 4'd1;
          if (r_wait_cnt <= 4'd1) begin
            w_next_state = S_ACK;
            w_enter_ack  = 1'b1;
          end
        end
      end
      S_ACK:   w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // The store itself is not reset, so its write strobe is masked while reset
  // is held to keep a request presented during reset from landing.
  assign w_do_write = w_enter_ack && w_acc_write && !w_acc_illegal && !i_rst;
  assign w_do_read  = w_enter_ack && !w_acc_write && !w_acc_illegal;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= 4'd0;
      r_addr     <= '0;
      r_is_write <= 1'b0;
      r_illegal  <= 1'b0;
      r_rdata    <= '0;
      r_rd_count <= 16'd0;
      r_wr_count <= 16'd0;
    end else begin
      r_state    <= w_next_state;
      r_wait_cnt <= w_wait_cnt_next;
      if ((r_state == S_IDLE) && i_cs) begin
        r_addr     <= i_addr;
        r_is_write <= i_we;
        r_illegal  <= (i_we == i_oe);
      end
      if (w_do_read) begin
        r_rdata <= r_mem[w_acc_addr];
      end
      if ((r_state == S_ACK) && !r_illegal) begin
        if (r_is_write) begin
          if (r_wr_count != 16'hFFFF) r_wr_count <= r_wr_count + 16'd1;
        end else begin
          if (r_rd_count != 16'hFFFF) r_rd_count <= r_rd_count + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_write) begin
      r_mem[w_acc_addr] <= io_data;
    end
  end

  assign o_ready    = (r_state == S_ACK);
  assign o_err      = (r_state == S_ACK) && r_illegal;
  assign o_rd_count = r_rd_count;
  assign o_wr_count = r_wr_count;

  // Drive follows the live control lines so read data stays on the bus for
  // as long as the initiator keeps cs/oe up; never drive against a write.
  assign io_data = (i_cs && i_oe && !i_we) ? r_rdata : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_mem_bus_responder.sv
// tb/tb_mem_bus_responder.sv - self-checking bench for mem_bus_responder
module tb_mem_bus_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] addr   [3];
  logic       cs     [3];
  logic       we     [3];
  logic       oe     [3];
  logic       drv_en [3];
  logic [7:0] drv    [3];
  logic       ready  [3];
  logic       err    [3];
  logic [15:0] rdc   [3];
  logic [15:0] wrc   [3];
  wire  [7:0] bus0, bus1, bus2;

  int checks = 0;
  int errors = 0;

  logic [7:0]  model_mem   [3][256];
  bit          model_valid [3][256];
  logic [15:0] model_rd    [3];
  logic [15:0] model_wr    [3];

  typedef struct {
    int          kind;   // 0 write, 1 read, 2 illegal
    logic [7:0]  a;
    logic [7:0]  d;
    logic [7:0]  exp_rd;
    logic [15:0] exp_wr;
    logic [15:0] exp_rdc;
  } vec_t;

  vec_t vecs [10];

  always #5 clk = ~clk;

  assign bus0 = drv_en[0] ? drv[0] : 8'bz;
  assign bus1 = drv_en[1] ? drv[1] : 8'bz;
  assign bus2 = drv_en[2] ? drv[2] : 8'bz;

  mem_bus_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .WAIT_STATES(0)) u_ws0 (
    .i_clk(clk), .i_rst(rst), .i_addr(addr[0]), .io_data(bus0),
    .i_cs(cs[0]), .i_we(we[0]), .i_oe(oe[0]), .o_ready(ready[0]), .o_err(err[0]),
    .o_rd_count(rdc[0]), .o_wr_count(wrc[0]));

  mem_bus_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .WAIT_STATES(3)) u_ws3 (
    .i_clk(clk), .i_rst(rst), .i_addr(addr[1]), .io_data(bus1),
    .i_cs(cs[1]), .i_we(we[1]), .i_oe(oe[1]), .o_ready(ready[1]), .o_err(err[1]),
    .o_rd_count(rdc[1]), .o_wr_count(wrc[1]));

  mem_bus_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .WAIT_STATES(5)) u_ws5 (
    .i_clk(clk), .i_rst(rst), .i_addr(addr[2]), .io_data(bus2),
    .i_cs(cs[2]), .i_we(we[2]), .i_oe(oe[2]), .o_ready(ready[2]), .o_err(err[2]),
    .o_rd_count(rdc[2]), .o_wr_count(wrc[2]));

  function automatic logic [7:0] busv(input int k);
    case (k)
      0:       return bus0;
      1:       return bus1;
      default: return bus2;
    endcase
  endfunction

  function automatic logic [7:0] pat(input int i);
    return 8'((i * 37) + 11);
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic release_bus(input int k);
    cs[k] = 1'b0; we[k] = 1'b0; oe[k] = 1'b0; drv_en[k] = 1'b0;
  endtask

  // Called at a negedge. Presents one access, waits (bounded) for ready and
  // checks latency, err and read data; updates the reference model.
  task automatic access(input int k, input int kind, input logic [7:0] a,
                        input logic [7:0] d, input int exp_lat, input bit keep,
                        input string nm, output logic [7:0] rd_got);
    int n;
    bit done;
    addr[k]   = a;
    cs[k]     = 1'b1;
    we[k]     = (kind != 1);
    oe[k]     = (kind != 0);
    drv[k]    = d;
    drv_en[k] = (kind != 1);
    n = 0;
    done = 1'b0;
    while (!done && n < 40) begin
      tick();
      n++;
      if (ready[k]) done = 1'b1;
    end
    rd_got = busv(k);
    chk({nm, "_lat"}, 32'(n), 32'(exp_lat));
    chk({nm, "_err"}, 32'(err[k]), 32'(kind == 2));
    if (kind == 0) begin
      model_mem[k][a]   = d;
      model_valid[k][a] = 1'b1;
      if (model_wr[k] != 16'hFFFF) model_wr[k] = model_wr[k] + 16'd1;
    end else if (kind == 1) begin
      if (model_valid[k][a]) chk({nm, "_model_rd"}, 32'(rd_got), 32'(model_mem[k][a]));
      if (model_rd[k] != 16'hFFFF) model_rd[k] = model_rd[k] + 16'd1;
    end
    if (!keep) release_bus(k);
  endtask

  task automatic cnt_chk(input int k, input string nm);
    tick();
    chk({nm, "_rdc"}, 32'(rdc[k]), 32'(model_rd[k]));
    chk({nm, "_wrc"}, 32'(wrc[k]), 32'(model_wr[k]));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [7:0] got;
    bit prev_keep;
    bit keep;
    int kind;
    int lat;
    int nready;

    vecs[0] = '{0, 8'h01, 8'h1C, 8'h00, 16'd1, 16'd0};
    vecs[1] = '{1, 8'h01, 8'h00, 8'h1C, 16'd1, 16'd1};
    vecs[2] = '{0, 8'h05, 8'h33, 8'h00, 16'd2, 16'd1};
    vecs[3] = '{0, 8'h7F, 8'hA5, 8'h00, 16'd3, 16'd1};
    vecs[4] = '{1, 8'h7F, 8'h00, 8'hA5, 16'd3, 16'd2};
    vecs[5] = '{1, 8'h05, 8'h00, 8'h33, 16'd3, 16'd3};
    vecs[6] = '{2, 8'h05, 8'h77, 8'h00, 16'd3, 16'd3};
    vecs[7] = '{1, 8'h05, 8'h00, 8'h33, 16'd3, 16'd4};
    vecs[8] = '{0, 8'h01, 8'hE4, 8'h00, 16'd4, 16'd4};
    vecs[9] = '{1, 8'h01, 8'h00, 8'hE4, 16'd4, 16'd5};

    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      addr[k] = 8'h00; drv[k] = 8'h00;
      release_bus(k);
      model_rd[k] = 16'd0; model_wr[k] = 16'd0;
    end
    repeat (3) tick();
    rst = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("reset_ready", 32'(ready[k]), 32'd0);
      chk("reset_err",   32'(err[k]),   32'd0);
      chk("reset_rdc",   32'(rdc[k]),   32'd0);
      chk("reset_wrc",   32'(wrc[k]),   32'd0);
    end

    // Table-driven accesses, zero wait states.
    for (int i = 0; i < 10; i++) begin
      access(0, vecs[i].kind, vecs[i].a, vecs[i].d, 1, 1'b0, $sformatf("vec%0d", i), got);
      if (vecs[i].kind == 1) chk($sformatf("vec%0d_rdata", i), 32'(got), 32'(vecs[i].exp_rd));
      tick();
      chk($sformatf("vec%0d_wrc", i), 32'(wrc[0]), 32'(vecs[i].exp_wr));
      chk($sformatf("vec%0d_rdc", i), 32'(rdc[0]), 32'(vecs[i].exp_rdc));
    end

    // Illegal request held with bench driving 00: a responder drive of the
    // stale E4 read data would show up on the bus.
    addr[0] = 8'h05; cs[0] = 1'b1; we[0] = 1'b1; oe[0] = 1'b1;
    drv[0] = 8'h00; drv_en[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("illegal_hiz", 32'(bus0), 32'h00);
      if (ready[0]) chk("illegal_err_with_ready", 32'(err[0]), 32'd1);
    end
    release_bus(0);
    tick();
    chk("illegal_wrc", 32'(wrc[0]), 32'd4);
    chk("illegal_rdc", 32'(rdc[0]), 32'd5);

    // 34 back-to-back writes with cs held high, then read back.
    for (int i = 0; i < 34; i++)
      access(0, 0, 8'(i), pat(i), (i == 0) ? 1 : 2, (i != 33), "b2b_wr", got);
    tick();
    chk("b2b_wrc", 32'(wrc[0]), 32'd38);
    for (int i = 0; i < 34; i++) begin
      access(0, 1, 8'(i), 8'h00, (i == 0) ? 1 : 2, (i != 33), "b2b_rd", got);
      chk($sformatf("b2b_rdata%0d", i), 32'(got), 32'(pat(i)));
    end
    tick();
    chk("b2b_rdc", 32'(rdc[0]), 32'd39);
    chk("b2b_wrc2", 32'(wrc[0]), 32'd38);

    // Three wait states.
    access(1, 0, 8'h20, 8'h0A, 4, 1'b0, "ws3_wr", got);
    cnt_chk(1, "ws3_wr");
    access(1, 1, 8'h20, 8'h00, 4, 1'b0, "ws3_rd", got);
    chk("ws3_rdata", 32'(got), 32'h0A);
    cnt_chk(1, "ws3_rd");
    oe[1] = 1'b1; drv[1] = 8'h00; drv_en[1] = 1'b1;
    tick();
    chk("ws3_hiz_no_cs", 32'(bus1), 32'h00);
    release_bus(1);

    // Randomized traffic against the reference model.
    prev_keep = 1'b0;
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 99);
      kind = (kind < 45) ? 0 : ((kind < 90) ? 1 : 2);
      keep = ($urandom_range(0, 3) == 0) && (i != 39);
      lat  = ((kind == 2) ? 1 : 4) + (prev_keep ? 1 : 0);
      access(1, kind, 8'($urandom_range(64, 255)), 8'($urandom), lat, keep,
             $sformatf("rnd%0d", i), got);
      if (!keep) cnt_chk(1, $sformatf("rnd%0d", i));
      prev_keep = keep;
    end

    // Five wait states: abort mid-wait.
    access(2, 0, 8'h10, 8'h44, 6, 1'b0, "ws5_pre", got);
    cnt_chk(2, "ws5_pre");
    addr[2] = 8'h10; cs[2] = 1'b1; we[2] = 1'b1; oe[2] = 1'b0;
    drv[2] = 8'hEE; drv_en[2] = 1'b1;
    nready = 0;
    repeat (2) begin
      tick();
      if (ready[2]) nready++;
    end
    release_bus(2);
    repeat (10) begin
      tick();
      if (ready[2]) nready++;
    end
    chk("abort_no_ready", 32'(nready), 32'd0);
    chk("abort_wrc", 32'(wrc[2]), 32'd1);
    access(2, 1, 8'h10, 8'h00, 6, 1'b0, "abort_rd", got);
    chk("abort_rdata", 32'(got), 32'h44);
    cnt_chk(2, "abort_rd");

    // Reset in the middle of a wait.
    access(2, 0, 8'h03, 8'h3C, 6, 1'b0, "rst_pre", got);
    cnt_chk(2, "rst_pre");
    addr[2] = 8'h03; cs[2] = 1'b1; we[2] = 1'b1; oe[2] = 1'b0;
    drv[2] = 8'hAB; drv_en[2] = 1'b1;
    repeat (2) tick();
    rst = 1'b1;
    release_bus(2);
    #1;
    chk("rst_ready", 32'(ready[2]), 32'd0);
    chk("rst_err",   32'(err[2]),   32'd0);
    chk("rst_rdc",   32'(rdc[2]),   32'd0);
    chk("rst_wrc",   32'(wrc[2]),   32'd0);
    for (int k = 0; k < 3; k++) begin
      model_rd[k] = 16'd0; model_wr[k] = 16'd0;
    end
    tick();
    chk("rst_ready_held", 32'(ready[2]), 32'd0);
    rst = 1'b0;
    tick();
    access(2, 1, 8'h03, 8'h00, 6, 1'b0, "rst_rd", got);
    chk("rst_rdata", 32'(got), 32'h3C);
    tick();
    chk("rst_rd_rdc", 32'(rdc[2]), 32'd1);
    chk("rst_rd_wrc", 32'(wrc[2]), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
